// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
// Latency: none (declarations only).
// Backpressure: n/a. The CRC state exists only when SPI_ARB_CRC_EN is defined.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_HDR,
        ST_WAIT,
        ST_PAY,
`ifdef SPI_ARB_CRC_EN
        ST_CRC,
`endif
        ST_GAP
    } state_e;

    // Header byte layout: channel id on top, payload length below it.
    localparam int HDR_CH_BIT  = 7;
    localparam int HDR_LEN_MSB = 6;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/spi_crc8.sv
// One byte step of CRC-8 (poly 0x07), MSB-first.
// Latency: combinational.
// Backpressure: none.
module spi_crc8
    import spi_arb_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] w_c;

    // Shift the byte through the polynomial divider one bit at a time.
    always_comb begin
        w_c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
        end
        crc_out = w_c;
    end

endmodule

// File: rtl/spi_tx_arb.sv
// Round-robin two-channel frame scheduler driving a shared SPI byte transmitter.
// Latency: req->gnt 1 cycle, ->cs_n low 2, ->first tx_start 3; gap of GAP_CYCLES+1 after cs_n rises.
// Backpressure: each tx_start waits for tx_busy=0; tx_done missing for TIMEOUT_CYCLES aborts. Macro SPI_ARB_CRC_EN appends a CRC-8 byte.
module spi_tx_arb
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] len0,
    input  logic [6:0] len1,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    output logic       rd0,
    output logic       rd1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       cs_n,
    output logic       busy,
    output logic       timeout_err,
    input  logic       err_clr
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        r_state, w_state;
    logic          r_ch, w_ch, r_last, w_last;
    logic [6:0]    r_len, w_len, r_rem, w_rem;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic          r_gnt0, w_gnt0, r_gnt1, w_gnt1;
    logic          r_rd0, w_rd0, r_rd1, w_rd1;
    logic          r_done0, w_done0, r_done1, w_done1;
    logic [7:0]    r_tx_byte, w_tx_byte;
    logic          r_tx_start, w_tx_start;
    logic          r_cs_n, w_cs_n, r_busy, w_busy, r_err, w_err;
    logic          w_pick;
    logic [7:0]    w_hdr, w_pay_byte;

    // Tie goes to the channel not granted last; a lone request wins outright.
    assign w_pick     = (req0 && req1) ? ~r_last : req1;
    assign w_pay_byte = r_ch ? byte1 : byte0;

    // Header byte assembled from the latched channel and length.
    always_comb begin
        w_hdr                  = '0;
        w_hdr[HDR_CH_BIT]      = r_ch;
        w_hdr[HDR_LEN_MSB:0]   = r_len;
    end

`ifdef SPI_ARB_CRC_EN
    logic [7:0] r_crc, w_crc, w_crc_step, w_crc_data;
    logic       r_crc_sent, w_crc_sent;

    // CRC runs over exactly the bytes handed to the transmitter.
    assign w_crc_data = (r_state == ST_PAY) ? w_pay_byte : w_hdr;

    spi_crc8 u_crc8 (
        .crc_in  (r_crc),
        .data    (w_crc_data),
        .crc_out (w_crc_step)
    );
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state    = r_state;
        w_ch       = r_ch;
        w_len      = r_len;
        w_rem      = r_rem;
        w_gap_cnt  = r_gap_cnt;
        w_to_cnt   = r_to_cnt;
        w_last     = r_last;
        w_gnt0     = r_gnt0;
        w_gnt1     = r_gnt1;
        w_rd0      = 1'b0;
        w_rd1      = 1'b0;
        w_done0    = 1'b0;
        w_done1    = 1'b0;
        w_tx_byte  = r_tx_byte;
        w_tx_start = 1'b0;
        w_cs_n     = r_cs_n;
        w_busy     = r_busy;
        w_err      = r_err & ~err_clr;
`ifdef SPI_ARB_CRC_EN
        w_crc      = r_crc;
        w_crc_sent = r_crc_sent;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_ch    = w_pick;
                    w_last  = w_pick;
                    w_len   = w_pick ? len1 : len0;
                    w_rem   = w_pick ? len1 : len0;
                    w_gnt0  = ~w_pick;
                    w_gnt1  = w_pick;
                    w_busy  = 1'b1;
                    w_state = ST_SEL;
`ifdef SPI_ARB_CRC_EN
                    w_crc      = CRC8_INIT;
                    w_crc_sent = 1'b0;
`endif
                end
            end
            ST_SEL: begin
                w_cs_n  = 1'b0;
                w_state = ST_HDR;
            end
            ST_HDR: begin
                if (!tx_busy) begin
                    w_tx_byte  = w_hdr;
                    w_tx_start = 1'b1;
                    w_to_cnt   = '0;
                    w_state    = ST_WAIT;
`ifdef SPI_ARB_CRC_EN
                    w_crc      = w_crc_step;
`endif
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (r_rem != 7'd0) begin
                        w_state = ST_PAY;
`ifdef SPI_ARB_CRC_EN
                    end else if (!r_crc_sent) begin
                        w_state = ST_CRC;
`endif
                    end else begin
                        w_cs_n    = 1'b1;
                        w_gap_cnt = '0;
                        w_state   = ST_GAP;
                    end
                end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: flag set overrides a same-cycle clear.
                    w_err     = 1'b1;
                    w_cs_n    = 1'b1;
                    w_gap_cnt = '0;
                    w_state   = ST_GAP;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            ST_PAY: begin
                if (!tx_busy) begin
                    w_tx_byte  = w_pay_byte;
                    w_tx_start = 1'b1;
                    w_rd0      = ~r_ch;
                    w_rd1      = r_ch;
                    w_rem      = r_rem - 1'b1;
                    w_to_cnt   = '0;
                    w_state    = ST_WAIT;
`ifdef SPI_ARB_CRC_EN
                    w_crc      = w_crc_step;
`endif
                end
            end
`ifdef SPI_ARB_CRC_EN
            ST_CRC: begin
                if (!tx_busy) begin
                    w_tx_byte  = r_crc;
                    w_tx_start = 1'b1;
                    w_crc_sent = 1'b1;
                    w_to_cnt   = '0;
                    w_state    = ST_WAIT;
                end
            end
`endif
            ST_GAP: begin
                if (r_gap_cnt == GW'(GAP_CYCLES)) begin
                    w_done0 = ~r_ch;
                    w_done1 = r_ch;
                    w_gnt0  = 1'b0;
                    w_gnt1  = 1'b0;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ch       <= 1'b0;
            r_last     <= 1'b1;
            r_len      <= '0;
            r_rem      <= '0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rd0      <= 1'b0;
            r_rd1      <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_tx_byte  <= '0;
            r_tx_start <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ch       <= w_ch;
            r_last     <= w_last;
            r_len      <= w_len;
            r_rem      <= w_rem;
            r_gap_cnt  <= w_gap_cnt;
            r_to_cnt   <= w_to_cnt;
            r_gnt0     <= w_gnt0;
            r_gnt1     <= w_gnt1;
            r_rd0      <= w_rd0;
            r_rd1      <= w_rd1;
            r_done0    <= w_done0;
            r_done1    <= w_done1;
            r_tx_byte  <= w_tx_byte;
            r_tx_start <= w_tx_start;
            r_cs_n     <= w_cs_n;
            r_busy     <= w_busy;
            r_err      <= w_err;
        end
    end

`ifdef SPI_ARB_CRC_EN
    // Running CRC accumulator and the per-frame "CRC already sent" marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc      <= CRC8_INIT;
            r_crc_sent <= 1'b0;
        end else begin
            r_crc      <= w_crc;
            r_crc_sent <= w_crc_sent;
        end
    end
`endif

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign rd0         = r_rd0;
    assign rd1         = r_rd1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign tx_byte     = r_tx_byte;
    assign tx_start    = r_tx_start;
    assign cs_n        = r_cs_n;
    assign busy        = r_busy;
    assign timeout_err = r_err;

endmodule
